// File: rtl/fwd_regfile_if.sv
// Decode/execute boundary bundle for the forwarding register file.
// The pipeline control side takes the master modport and the register file takes the slave modport.
interface fwd_regfile_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NRD    = 2
);
    logic                    id_valid;
    logic [NRD-1:0]          rd_en;
    logic [NRD*ADDR_W-1:0]   rd_addr;
    logic                    ex_wr_en;
    logic                    ex_is_load;
    logic [ADDR_W-1:0]       ex_wr_addr;
    logic [DATA_W-1:0]       ex_wr_data;
    logic                    wb_wr_en;
    logic [ADDR_W-1:0]       wb_wr_addr;
    logic [DATA_W-1:0]       wb_wr_data;
    logic                    hold;
    logic                    flush;
    logic                    stall;
    logic                    exe_valid;
    logic [NRD*DATA_W-1:0]   exe_rd_data;

    modport master (
        output id_valid, rd_en, rd_addr,
        output ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
        output wb_wr_en, wb_wr_addr, wb_wr_data,
        output hold, flush,
        input  stall, exe_valid, exe_rd_data
    );

    modport slave (
        input  id_valid, rd_en, rd_addr,
        input  ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
        input  wb_wr_en, wb_wr_addr, wb_wr_data,
        input  hold, flush,
        output stall, exe_valid, exe_rd_data
    );
endinterface

// File: rtl/fwd_regfile.sv
// Register file with EXE/WB forwarding, load-use stall detection and a registered
// decode/execute output stage that supports hold (with WB refresh) and flush.
module fwd_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NREG     = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic          clk,
    input logic          rst,
    fwd_regfile_if.slave bus
);
    logic [DATA_W-1:0]     r_mem [NREG];
    logic [NRD*ADDR_W-1:0] r_cap_addr;
    logic [NRD-1:0]        r_cap_en;
    logic                  r_exe_valid;
    logic [NRD*DATA_W-1:0] r_exe_data;

    logic [NRD*DATA_W-1:0] w_opnd;
    logic [NRD*DATA_W-1:0] w_hold_data;
    logic [NRD-1:0]        w_port_stall;
    logic                  w_wb_ok;
    logic                  w_stall;

    // Excluded addresses (out of range, or the hard-wired zero register) never read, write or stall.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < NREG) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        w_wb_ok      = bus.wb_wr_en && addr_ok(bus.wb_wr_addr);
        w_opnd       = '0;
        w_port_stall = '0;
        w_hold_data  = r_exe_data;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (bus.rd_en[i] && addr_ok(bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
                if (bus.ex_wr_en && !bus.ex_is_load &&
                    (bus.rd_addr[i*ADDR_W +: ADDR_W] == bus.ex_wr_addr)) begin
                    w_opnd[i*DATA_W +: DATA_W] = bus.ex_wr_data;
                end else if (bus.wb_wr_en &&
                             (bus.rd_addr[i*ADDR_W +: ADDR_W] == bus.wb_wr_addr)) begin
                    w_opnd[i*DATA_W +: DATA_W] = bus.wb_wr_data;
                end else begin
                    w_opnd[i*DATA_W +: DATA_W] = r_mem[bus.rd_addr[i*ADDR_W +: ADDR_W]];
                end
                if (bus.ex_wr_en && bus.ex_is_load &&
                    (bus.rd_addr[i*ADDR_W +: ADDR_W] == bus.ex_wr_addr)) begin
                    w_port_stall[i] = 1'b1;
                end
            end
            // A held operand must still see WB results for its captured register.
            if (r_cap_en[i] && w_wb_ok &&
                (r_cap_addr[i*ADDR_W +: ADDR_W] == bus.wb_wr_addr)) begin
                w_hold_data[i*DATA_W +: DATA_W] = bus.wb_wr_data;
            end
        end
        w_stall = bus.id_valid && (|w_port_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem       <= '{default: '0};
            r_exe_valid <= 1'b0;
            r_exe_data  <= '0;
            r_cap_addr  <= '0;
            r_cap_en    <= '0;
        end else begin
            if (w_wb_ok) begin
                r_mem[bus.wb_wr_addr] <= bus.wb_wr_data;
            end
            if (bus.flush) begin
                r_exe_valid <= 1'b0;
                r_exe_data  <= '0;
                r_cap_en    <= '0;
            end else if (bus.hold) begin
                r_exe_data  <= w_hold_data;
            end else if (w_stall) begin
                r_exe_valid <= 1'b0;
                r_exe_data  <= '0;
                r_cap_en    <= '0;
            end else begin
                r_exe_valid <= bus.id_valid;
                r_exe_data  <= w_opnd;
                r_cap_addr  <= bus.rd_addr;
                r_cap_en    <= bus.rd_en;
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.exe_valid   = r_exe_valid;
    assign bus.exe_rd_data = r_exe_data;
endmodule

// File: tb/tb_fwd_regfile.sv
// Directed vector bench for fwd_regfile (NREG=12 so out-of-range addresses exist, ZERO_REG=1).
// Each record drives one cycle, checks the combinational stall before the edge and the stage after it.
module tb_fwd_regfile;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_regfile_if #(.DATA_W(16), .ADDR_W(4), .NRD(2)) bus ();

    fwd_regfile #(
        .DATA_W  (16),
        .NREG    (12),
        .ADDR_W  (4),
        .NRD     (2),
        .ZERO_REG(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        rst;
        logic        idv;
        logic [1:0]  en;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic        ex_en;
        logic        ex_ld;
        logic [3:0]  ex_a;
        logic [15:0] ex_d;
        logic        wb_en;
        logic [3:0]  wb_a;
        logic [15:0] wb_d;
        logic        hold;
        logic        flush;
        logic        e_stall;
        logic        e_valid;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
    } vec_t;

    vec_t tbl[$];
    vec_t seq[$];

    function automatic vec_t mk(int r, int idv, int en, int a0, int a1,
                                int exen, int exld, int exa, int exd,
                                int wben, int wba, int wbd, int hold, int flush,
                                int es, int ev, int e0, int e1);
        vec_t t;
        t.rst = 1'(r);       t.idv = 1'(idv);     t.en = 2'(en);
        t.a0 = 4'(a0);       t.a1 = 4'(a1);
        t.ex_en = 1'(exen);  t.ex_ld = 1'(exld);  t.ex_a = 4'(exa);  t.ex_d = 16'(exd);
        t.wb_en = 1'(wben);  t.wb_a = 4'(wba);    t.wb_d = 16'(wbd);
        t.hold = 1'(hold);   t.flush = 1'(flush);
        t.e_stall = 1'(es);  t.e_valid = 1'(ev);  t.e_d0 = 16'(e0);  t.e_d1 = 16'(e1);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        rst              = t.rst;
        bus.id_valid     = t.idv;
        bus.rd_en        = t.en;
        bus.rd_addr      = {t.a1, t.a0};
        bus.ex_wr_en     = t.ex_en;
        bus.ex_is_load   = t.ex_ld;
        bus.ex_wr_addr   = t.ex_a;
        bus.ex_wr_data   = t.ex_d;
        bus.wb_wr_en     = t.wb_en;
        bus.wb_wr_addr   = t.wb_a;
        bus.wb_wr_data   = t.wb_d;
        bus.hold         = t.hold;
        bus.flush        = t.flush;
        #1;
        chk({tag, " stall"}, 16'(bus.stall), 16'(t.e_stall));
        @(posedge clk);
        #1;
        chk({tag, " exe_valid"}, 16'(bus.exe_valid), 16'(t.e_valid));
        chk({tag, " data0"}, bus.exe_rd_data[15:0], t.e_d0);
        chk({tag, " data1"}, bus.exe_rd_data[31:16], t.e_d1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.rd_en = '0; bus.rd_addr = '0;
        bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0; bus.ex_wr_addr = '0; bus.ex_wr_data = '0;
        bus.wb_wr_en = 1'b0; bus.wb_wr_addr = '0; bus.wb_wr_data = '0;
        bus.hold = 1'b0; bus.flush = 1'b0;

        //              rst idv en a0  a1  exen ld exa exd      wben wba wbd     hld fl  stl vld d0       d1
        tbl.push_back(mk(1, 1, 1, 3,  0,  0, 0, 0,  0,       1, 3,  'h1234, 0, 0,  0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 1, 3,  0,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 0,       0));
        tbl.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0,  0,       1, 5,  'hBEEF, 0, 0,  0, 1, 'hBEEF,  0));
        tbl.push_back(mk(0, 1, 2, 5,  2,  1, 0, 2,  'h00AA,  1, 2,  'h0055, 0, 0,  0, 1, 0,       'h00AA));
        tbl.push_back(mk(0, 1, 3, 2,  5,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 'h0055,  'hBEEF));
        tbl.push_back(mk(0, 1, 1, 7,  0,  1, 1, 7,  'h7777,  0, 0,  0,      0, 0,  1, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 7,  0,  1, 1, 7,  'h7777,  0, 0,  0,      0, 0,  0, 1, 0,       0));
        tbl.push_back(mk(0, 0, 1, 7,  0,  1, 1, 7,  'h7777,  0, 0,  0,      0, 0,  0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  0, 0, 0,  0,       1, 0,  'hFFFF, 0, 0,  0, 1, 0,       0));
        tbl.push_back(mk(0, 1, 3, 5,  0,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 'hBEEF,  0));
        tbl.push_back(mk(0, 1, 3, 12, 13, 1, 1, 12, 'h1212,  1, 12, 'h7777, 0, 0,  0, 1, 0,       0));
        tbl.push_back(mk(0, 1, 3, 11, 4,  1, 0, 4,  'h4444,  1, 11, 'h0B0B, 0, 0,  0, 1, 'h0B0B,  'h4444));
        tbl.push_back(mk(0, 1, 1, 11, 0,  0, 1, 11, 'hDEAD,  0, 0,  0,      0, 0,  0, 1, 'h0B0B,  0));
        tbl.push_back(mk(0, 1, 3, 5,  11, 1, 1, 11, 'hDEAD,  0, 0,  0,      0, 0,  1, 0, 0,       0));
        tbl.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0,  0,       0, 0,  0,      0, 1,  0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  1, 1, 0,  'hDEAD,  0, 0,  0,      0, 0,  0, 1, 0,       0));
        tbl.push_back(mk(0, 1, 1, 5,  0,  1, 1, 5,  'hDEAD,  1, 9,  'h0909, 0, 0,  1, 0, 0,       0));
        tbl.push_back(mk(0, 1, 3, 9,  4,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 'h0909,  0));
        tbl.push_back(mk(0, 1, 3, 9,  2,  1, 0, 9,  'h1111,  0, 0,  0,      0, 0,  0, 1, 'h1111,  'h0055));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Hold with WB refresh of captured ports, hold beating stall, flush beating hold, reset beating all.
        seq.push_back(mk(0, 1, 3, 4,  5,  0, 0, 0,  0,       1, 4,  'h0001, 0, 0,  0, 1, 'h0001,  'hBEEF));
        seq.push_back(mk(0, 1, 1, 9,  0,  0, 0, 0,  0,       0, 0,  0,      1, 0,  0, 1, 'h0001,  'hBEEF));
        seq.push_back(mk(0, 1, 1, 9,  0,  0, 0, 0,  0,       1, 4,  'h0099, 1, 0,  0, 1, 'h0099,  'hBEEF));
        seq.push_back(mk(0, 1, 1, 9,  0,  0, 0, 0,  0,       1, 5,  'h5555, 1, 0,  0, 1, 'h0099,  'h5555));
        seq.push_back(mk(0, 1, 1, 9,  0,  1, 1, 9,  'hDEAD,  0, 0,  0,      1, 0,  1, 1, 'h0099,  'h5555));
        seq.push_back(mk(0, 1, 3, 4,  5,  0, 0, 0,  0,       0, 0,  0,      1, 1,  0, 0, 0,       0));
        seq.push_back(mk(0, 1, 3, 4,  5,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 'h0099,  'h5555));
        seq.push_back(mk(1, 1, 3, 4,  5,  0, 0, 0,  0,       1, 6,  'hABCD, 1, 0,  0, 0, 0,       0));
        seq.push_back(mk(0, 1, 3, 4,  6,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 0,       0));
        seq.push_back(mk(0, 1, 1, 4,  3,  0, 0, 0,  0,       0, 0,  0,      0, 0,  0, 1, 0,       0));
        seq.push_back(mk(0, 1, 1, 4,  3,  0, 0, 0,  0,       1, 3,  'h3333, 1, 0,  0, 1, 0,       0));

        for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("hold%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
